// File: rtl/alu_md_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification helpers
// for the iterative multiply/divide ALU.
package alu_md_pkg;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_SLL    = 5'd2;
   localparam logic [4:0] ALU_SLT    = 5'd3;
   localparam logic [4:0] ALU_SLTU   = 5'd4;
   localparam logic [4:0] ALU_XOR    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_OR     = 5'd8;
   localparam logic [4:0] ALU_AND    = 5'd9;
   localparam logic [4:0] ALU_MUL    = 5'd10;
   localparam logic [4:0] ALU_MULH   = 5'd11;
   localparam logic [4:0] ALU_MULHSU = 5'd12;
   localparam logic [4:0] ALU_MULHU  = 5'd13;
   localparam logic [4:0] ALU_DIV    = 5'd14;
   localparam logic [4:0] ALU_DIVU   = 5'd15;
   localparam logic [4:0] ALU_REM    = 5'd16;
   localparam logic [4:0] ALU_REMU   = 5'd17;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op >= ALU_MUL) && (op <= ALU_REMU);
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return (op >= ALU_DIV) && (op <= ALU_REMU);
   endfunction

   function automatic logic is_signed_a(input logic [4:0] op);
      return (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
   endfunction

   function automatic logic is_signed_b(input logic [4:0] op);
      return (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
   endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Shared unsigned datapath: shift-add multiply or restoring divide, one step per cycle.
// The first step is taken on the start edge so DATA_WIDTH steps end one cycle before done clears.
module alu_md_iter
   import alu_md_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    kill,
   input  logic                    div_mode,
   input  logic [DATA_WIDTH-1:0]   a_mag,
   input  logic [DATA_WIDTH-1:0]   b_mag,
   output logic [2*DATA_WIDTH-1:0] res,
   output logic                    done
);

   localparam int AW = 2*DATA_WIDTH + 1;
   localparam int CW = $clog2(DATA_WIDTH) + 1;

   logic [AW-1:0]         acc;
   logic [AW-1:0]         acc_src;
   logic [AW-1:0]         acc_step;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] b_src;
   logic                  mode_q;
   logic                  mode_src;
   logic [CW-1:0]         cnt;
   logic                  active;

   // Mul: add multiplicand into the upper half on lsb, shift right.
   // Div: shift left, subtract divisor from upper half when it fits, quotient bit into lsb.
   function automatic logic [AW-1:0] step(input logic [AW-1:0] a,
                                          input logic [DATA_WIDTH-1:0] b,
                                          input logic dv);
      logic [AW-1:0]       sh;
      logic [DATA_WIDTH:0] hi;
      logic [DATA_WIDTH:0] sum;
      sh  = '0;
      hi  = '0;
      sum = '0;
      if (dv) begin
         sh = {a[AW-2:0], 1'b0};
         hi = sh[AW-1:DATA_WIDTH];
         if (hi >= {1'b0, b}) begin
            sh[AW-1:DATA_WIDTH] = hi - {1'b0, b};
            sh[0] = 1'b1;
         end
      end else begin
         sum = a[AW-1:DATA_WIDTH] + (a[0] ? {1'b0, b} : '0);
         sh  = {1'b0, sum, a[DATA_WIDTH-1:1]};
      end
      return sh;
   endfunction

   always_comb begin
      acc_src  = start ? {{(DATA_WIDTH+1){1'b0}}, a_mag} : acc;
      b_src    = start ? b_mag : b_q;
      mode_src = start ? div_mode : mode_q;
      acc_step = step(acc_src, b_src, mode_src);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         b_q    <= '0;
         mode_q <= 1'b0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (kill) begin
         cnt    <= '0;
         active <= 1'b0;
      end else if (start) begin
         acc    <= acc_step;
         b_q    <= b_mag;
         mode_q <= div_mode;
         cnt    <= CW'(DATA_WIDTH - 1);
         active <= 1'b1;
      end else if (active) begin
         if (cnt != '0) begin
            acc <= acc_step;
            cnt <= cnt - 1'b1;
         end else begin
            active <= 1'b0;
         end
      end
   end

   assign done = active && (cnt == '0);
   assign res  = acc[AW-2:0];

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU with iterative RV32M multiply/divide behind valid/ready handshakes.
//   state  | meaning
//   S_IDLE | empty, ready for a new op
//   S_CALC | mul/div iterating in alu_md_iter
//   S_DONE | result held on alu_res until out_ready
module alu_md
   import alu_md_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] alu_in_rs1,
   input  logic [DATA_WIDTH-1:0] alu_in_rs2,
   input  logic [4:0]            alu_ctrl,
   input  logic                  kill,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] alu_res,
   output logic                  busy
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   state_t           state;
   logic [4:0]       op_q;
   logic             neg_q;

   logic [SHAMT_W-1:0] shamt;
   logic [W-1:0]     base_res;
   logic [W-1:0]     fast_res;
   logic [W-1:0]     op_res;
   logic [W-1:0]     a_mag;
   logic [W-1:0]     b_mag;
   logic [W-1:0]     fix_res;
   logic [W-1:0]     quo;
   logic [W-1:0]     rem;
   logic [2*W-1:0]   prod;
   logic [2*W-1:0]   iter_res;
   logic             iter_done;
   logic             a_neg;
   logic             b_neg;
   logic             neg_d;
   logic             div_zero;
   logic             div_ovf;
   logic             rem_op;
   logic             fast;
   logic             accept;
   logic             start;

   assign in_ready = !rst && !kill && (state == S_IDLE || (state == S_DONE && out_ready));
   assign busy     = (state == S_CALC);

   always_comb begin
      shamt = alu_in_rs2[SHAMT_W-1:0];
      case (alu_ctrl)
         ALU_SUB:  base_res = alu_in_rs1 - alu_in_rs2;
         ALU_SLL:  base_res = alu_in_rs1 << shamt;
         ALU_SLT:  base_res = {{(W-1){1'b0}}, ($signed(alu_in_rs1) < $signed(alu_in_rs2))};
         ALU_SLTU: base_res = {{(W-1){1'b0}}, (alu_in_rs1 < alu_in_rs2)};
         ALU_XOR:  base_res = alu_in_rs1 ^ alu_in_rs2;
         ALU_SRL:  base_res = alu_in_rs1 >> shamt;
         ALU_SRA:  base_res = W'($signed(alu_in_rs1) >>> shamt);
         ALU_OR:   base_res = alu_in_rs1 | alu_in_rs2;
         ALU_AND:  base_res = alu_in_rs1 & alu_in_rs2;
         default:  base_res = alu_in_rs1 + alu_in_rs2;
      endcase

      a_neg  = is_signed_a(alu_ctrl) && alu_in_rs1[W-1];
      b_neg  = is_signed_b(alu_ctrl) && alu_in_rs2[W-1];
      a_mag  = a_neg ? -alu_in_rs1 : alu_in_rs1;
      b_mag  = b_neg ? -alu_in_rs2 : alu_in_rs2;
      rem_op = (alu_ctrl == ALU_REM) || (alu_ctrl == ALU_REMU);
      // Remainder takes the dividend's sign; quotient and product take the xor.
      neg_d  = rem_op ? a_neg : (a_neg ^ b_neg);

      div_zero = (alu_in_rs2 == '0);
      div_ovf  = ((alu_ctrl == ALU_DIV) || (alu_ctrl == ALU_REM)) &&
                 (alu_in_rs1 == MOST_NEG) && (alu_in_rs2 == '1);
      fast     = is_div(alu_ctrl) && (div_zero || div_ovf);
      if (div_zero) fast_res = rem_op ? alu_in_rs1 : '1;
      else          fast_res = rem_op ? '0 : alu_in_rs1;

      op_res = fast ? fast_res : base_res;
      accept = in_valid && in_ready;
      start  = accept && is_muldiv(alu_ctrl) && !fast;

      prod = neg_q ? -iter_res : iter_res;
      quo  = neg_q ? -iter_res[W-1:0] : iter_res[W-1:0];
      rem  = neg_q ? -iter_res[2*W-1:W] : iter_res[2*W-1:W];
      case (op_q)
         ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_res = prod[2*W-1:W];
         ALU_DIV, ALU_DIVU:               fix_res = quo;
         ALU_REM, ALU_REMU:               fix_res = rem;
         default:                         fix_res = prod[W-1:0];
      endcase
   end

   alu_md_iter #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_iter (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .kill     (kill),
      .div_mode (is_div(alu_ctrl)),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .res      (iter_res),
      .done     (iter_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         alu_res   <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
      end else if (kill) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  if (start) begin
                     state     <= S_CALC;
                     out_valid <= 1'b0;
                     op_q      <= alu_ctrl;
                     neg_q     <= neg_d;
                  end else begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     alu_res   <= op_res;
                  end
               end else if (state == S_DONE && out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            S_CALC: begin
               if (iter_done) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  alu_res   <= fix_res;
               end
            end
            default: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: directed vectors push expected results, a monitor pops on each handshake.
module tb_alu_md;
   import alu_md_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] rs1 = '0;
   logic [W-1:0] rs2 = '0;
   logic [4:0]   ctrl = '0;
   logic         kill = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] alu_res;
   logic         busy;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;

   alu_md #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_in_rs1 (rs1),
      .alu_in_rs2 (rs2),
      .alu_ctrl   (ctrl),
      .kill       (kill),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_res    (alu_res),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h expected none", alu_res);
         end else begin
            mon_exp = exp_q.pop_front();
            check("result", alu_res, mon_exp);
         end
      end
   end

   task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok;
      ok       = 1'b0;
      ctrl     = op;
      rs1      = a;
      rs2      = b;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("accept", W'(ok), W'(1));
   endtask

   task automatic run(input string nm, input logic [4:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp,
                      input int exp_lat, input int exp_busy);
      int lat;
      int bc;
      exp_q.push_back(exp);
      send(op, a, b);
      lat = 1;
      bc  = 0;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         if (busy) bc++;
         @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, W'(lat), W'(exp_lat));
      check({nm, "_busy_cycles"}, W'(bc), W'(exp_busy));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_n;
      #2;
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_alu_res", alu_res, '0);
      check("rst_busy", W'(busy), W'(0));
      check("rst_in_ready", W'(in_ready), W'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", W'(in_ready), W'(1));
      @(posedge clk);
      #1;

      // Back-to-back base ops with no bubble
      exp_q.push_back(32'd2);
      exp_q.push_back(32'hF800_0000);
      send(ALU_ADD, 32'd5, 32'hFFFF_FFFD);
      send(ALU_SRA, 32'h8000_0000, 32'd4);
      @(negedge clk);
      check("b2b_sra_valid", W'(out_valid), W'(1));
      @(posedge clk);
      #1;

      run("sub",      ALU_SUB,  32'd5,        32'd3,        32'd2,        1, 0);
      run("sll_mask", ALU_SLL,  32'd1,        32'd33,       32'd2,        1, 0);
      run("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'd1,       32'd1,        1, 0);
      run("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0,        1, 0);
      run("xor",      ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 0);
      run("srl",      ALU_SRL,  32'h8000_0000, 32'd4,       32'h0800_0000, 1, 0);
      run("or",       ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1, 0);
      run("and",      ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 0);
      run("op20_add", 5'd20,    32'd10,       32'd20,       32'd30,       1, 0);

      run("mulh",     ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 32);
      run("mulhsu",   ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32);
      run("mul_neg",  ALU_MUL,    32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 33, 32);
      run("mulhu",    ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32);
      run("mulh_neg", ALU_MULH,   32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFFF, 33, 32);

      run("div_m7_2", ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 32);
      run("rem_m7_2", ALU_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 32);
      run("divu",     ALU_DIVU, 32'd100,       32'd7,         32'd14,        33, 32);
      run("remu",     ALU_REMU, 32'd100,       32'd7,         32'd2,         33, 32);
      run("div_7_m2", ALU_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 32);
      run("rem_7_m2", ALU_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33, 32);
      run("divu_big", ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 32);

      run("div_by0",  ALU_DIV,  32'd1234,      32'd0,         32'hFFFF_FFFF, 1, 0);
      run("rem_by0",  ALU_REM,  32'd1234,      32'd0,         32'd1234,      1, 0);
      run("divu_by0", ALU_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
      run("remu_by0", ALU_REMU, 32'd5,         32'd0,         32'd5,         1, 0);
      run("div_ovf",  ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run("rem_ovf",  ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);

      // Backpressure, then handoff to a new op on the releasing edge
      out_ready = 1'b0;
      exp_q.push_back(32'd15);
      send(ALU_MUL, 32'd3, 32'd5);
      wait_n = 0;
      @(negedge clk);
      while (!out_valid && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      check("bp_valid_seen", W'(out_valid), W'(1));
      repeat (5) begin
         @(negedge clk);
         check("bp_out_valid", W'(out_valid), W'(1));
         check("bp_alu_res", alu_res, 32'd15);
         check("bp_in_ready", W'(in_ready), W'(0));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      exp_q.push_back(32'h1234_5678 ^ 32'h0F0F_0F0F);
      send(ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
      @(negedge clk);
      check("handoff_valid", W'(out_valid), W'(1));
      @(posedge clk);
      #1;

      // Kill mid-divide; an add presented in the kill cycle must be dropped
      send(ALU_DIV, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      check("kill_pre_busy", W'(busy), W'(1));
      kill     = 1'b1;
      ctrl     = ALU_ADD;
      rs1      = 32'd1;
      rs2      = 32'd1;
      in_valid = 1'b1;
      @(negedge clk);
      check("kill_in_ready", W'(in_ready), W'(0));
      @(posedge clk);
      #1;
      kill     = 1'b0;
      in_valid = 1'b0;
      check("kill_busy", W'(busy), W'(0));
      check("kill_out_valid", W'(out_valid), W'(0));
      run("post_kill_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1, 0);

      // Asynchronous reset in the middle of a multiply
      send(ALU_MUL, 32'd9, 32'd9);
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_out_valid", W'(out_valid), W'(0));
      check("arst_alu_res", alu_res, '0);
      check("arst_busy", W'(busy), W'(0));
      check("arst_in_ready", W'(in_ready), W'(0));
      @(posedge clk);
      #1;
      check("arst_hold_in_ready", W'(in_ready), W'(0));
      rst = 1'b0;
      run("post_rst_add", ALU_ADD, 32'd7, 32'd8, 32'd15, 1, 0);
      run("post_rst_mul", ALU_MUL, 32'd6, 32'd7, 32'd42, 33, 32);

      repeat (3) @(posedge clk);
      check("queue_empty", W'(exp_q.size()), W'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
Parametrised successor to the EX-stage combinational ALU. It adds the RV32M multiply/divide/remainder operations, computed iteratively over DATA_WIDTH cycles. Both operand intake and result return use valid/ready handshakes, so the EX stage can stall on long operations. Base integer ops keep single-cycle registered latency. A kill input flushes in-flight work on a pipeline redirect.

Parameters:
DATA_WIDTH, 32, operand/result width; must be >= 8 and a power of two
SHAMT_W, $clog2(DATA_WIDTH), number of shift-amount bits taken from rs2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands and op presented
in_ready  out  1  block accepts an op this cycle
alu_in_rs1  in  DATA_WIDTH  operand 1
alu_in_rs2  in  DATA_WIDTH  operand 2
alu_ctrl  in  5  operation code (see Behaviour)
kill  in  1  flush: abandon the current op and drop the pending result
out_valid  out  1  alu_res is valid
out_ready  in  1  consumer takes the result
alu_res  out  DATA_WIDTH  result
busy  out  1  high in CALC state

Behaviour:
- Opcodes, base group:
  - 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
  - Shifts use rs2[SHAMT_W-1:0].
- Opcodes, multiply group:
  - 10 mul, 11 mulh, 12 mulhsu, 13 mulhu.
  - mul returns the low DATA_WIDTH bits of the product; the mulh variants return the high bits of the 2*DATA_WIDTH product.
- Opcodes, divide group: 14 div, 15 divu, 16 rem, 17 remu.
- Opcodes 18-31 behave as add.
- States:
  - IDLE: empty, in_ready=1.
  - CALC: iterating.
  - DONE: result held, out_valid=1.
- Accept: an op is accepted when in_valid && in_ready are both high on a clk edge.
- Base-group ops: go IDLE->DONE; out_valid rises on the edge after acceptance (latency 1).
- MUL/DIV ops: go IDLE->CALC.
  - Operands are converted to magnitudes per signedness and one shift-add (mul) or restoring-subtract (div) step runs per cycle.
  - CALC lasts exactly DATA_WIDTH cycles.
  - After that, sign correction is applied and the state moves to DONE.
  - out_valid rises DATA_WIDTH+1 edges after acceptance.
- Divide fast paths (latency 1, CALC skipped):
  - rs2==0: quotient = all ones, remainder = rs1.
  - Signed overflow (rs1 = most-negative value, rs2 = -1, div/rem only): quotient = rs1, remainder = 0.
- Remainder sign follows the dividend; quotient rounds toward zero.
- DONE: alu_res and out_valid stay stable until out_ready.
  - On an edge with out_ready high, the state leaves DONE.
  - If in_valid is also high, the new op is accepted on the same edge (go to CALC or stay in DONE). Otherwise go to IDLE.
- in_ready = !rst && !kill && (state==IDLE || (state==DONE && out_ready)). Combinational; it does not depend on in_valid.
- in_ready is low throughout CALC; inputs presented during CALC are ignored.
- kill has priority over everything:
  - Next edge forces IDLE, out_valid=0, and clears the iteration counter.
  - Any op presented in the same cycle is not accepted.
  - A result in DONE is discarded.
- Reset (asynchronous, mid-operation included): state=IDLE, out_valid=0, alu_res=0, busy=0, counter=0, datapath registers 0.
- Width rules:
  - Internal product/remainder accumulator is 2*DATA_WIDTH+1 bits.
  - Counter is $clog2(DATA_WIDTH)+1 bits.
  - slt/sltu return zero-extended 1/0.

Decomposition:
- Package alu_md_pkg holds:
  - opcode localparams (ALU_ADD..ALU_REMU, 5 bits)
  - state encoding (IDLE/CALC/DONE)
  - helper functions is_muldiv(op), is_signed_a(op), is_signed_b(op)
- One natural sub-module: alu_md_iter, the shared shift-add/restoring-divide datapath.
  - Inputs: magnitudes, start, mode; output: raw 2*DATA_WIDTH result and done.
  - The top level keeps the FSM, the base combinational ops, sign fix-up, fast paths and the handshake.

Test Plan:
- Base op: add, rs1=5, rs2=-3, out_ready=1 -> out_valid one edge after accept, alu_res=2. Back-to-back sra of 0x80000000 by 4 -> 0xF8000000 on the next edge, with no bubble.
- Multiply: mulh, rs1=0x80000000, rs2=0x80000000 -> busy for 32 cycles, out_valid at edge 33, alu_res=0x40000000. mulhsu, rs1=-1, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- Divide: div -7/2 -> -3 and rem -7/2 -> -1 at latency 33. divu 100/7 -> 14. remu 100/7 -> 2.
- Divide corner cases: div 1234/0 -> 0xFFFFFFFF and rem 1234/0 -> 1234, each at latency 1. div 0x80000000/-1 -> 0x80000000 and rem -> 0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after a mul completes -> alu_res and out_valid stable, in_ready=0. Then raise out_ready with in_valid=1 (xor) -> handoff on the same edge, xor result valid on the next edge.
- Flush and reset: assert kill at cycle 10 of a div -> next edge IDLE, out_valid never rises, and a new add is accepted the cycle after. Assert rst mid-CALC -> all outputs 0 immediately, in_ready=0 while rst is high.
